watchdog_timer_mc: RTL and testbench

- Multi-channel, parametrised successor to the single-channel MMIO watchdog.
- Each of NUM_CH independent channels has:
  - a countdown counter,
  - a pre-timeout warning,
  - an optional window (early-feed) check,
  - a key-protected feed,
  - a lock bit,
  - sticky write-1-to-clear (W1C) status.
- Sits on the core's data-memory MMIO bus. Drives per-channel interrupts and one system reset-request pulse.

---
 rtl/wdt_pkg.sv | 49 ++++
 rtl/wdt_channel.sv | 127 ++++++++++++
 rtl/watchdog_timer_mc.sv | 97 +++++++++
 tb/tb_watchdog_timer_mc.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wdt_pkg.sv
// Shared types and register-map constants for the multi-channel watchdog.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package wdt_pkg;

    // Per-channel FSM state
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_WARN   = 2'd2,
        ST_EXPIRE = 2'd3
    } wdt_state_t;

    // CTRL register layout, bit 0 (en) is the LSB
    typedef struct packed {
        logic lock;
        logic win_en;
        logic rst_en;
        logic irq_en;
        logic en;
    } wdt_ctrl_t;

    localparam int CTRL_W = 5;
    localparam int STAT_W = 4;

    // Register offsets within one channel block
    localparam logic [4:0] OFF_CTRL    = 5'h00;
    localparam logic [4:0] OFF_TIMEOUT = 5'h04;
    localparam logic [4:0] OFF_WINDOW  = 5'h08;
    localparam logic [4:0] OFF_FEED    = 5'h0C;
    localparam logic [4:0] OFF_STATUS  = 5'h10;

    // CTRL bit indices
    localparam int CTRL_EN     = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int CTRL_RST_EN = 2;
    localparam int CTRL_WIN_EN = 3;
    localparam int CTRL_LOCK   = 4;

    // STATUS bit indices
    localparam int STAT_WARN    = 0;
    localparam int STAT_EXPIRED = 1;
    localparam int STAT_EARLY   = 2;
    localparam int STAT_BAD_KEY = 3;

    // Address distance between consecutive channel blocks
    localparam logic [31:0] CH_STRIDE = 32'h20;

endpackage

// File: rtl/wdt_channel.sv
// One watchdog channel: config registers, countdown FSM, sticky W1C status.
// Latency: register writes and FSM updates take effect at the write edge.
// Backpressure: none; every MMIO access is accepted in the cycle it is presented.
module wdt_channel
    import wdt_pkg::*;
#(
    parameter int          CNT_W    = 32,
    parameter logic [31:0] FEED_KEY = 32'h0000_A5A5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_ctrl,
    input  logic              wr_timeout,
    input  logic              wr_window,
    input  logic              wr_feed,
    input  logic              wr_status,
    input  logic [31:0]       wdata,
    output logic [CTRL_W-1:0] ctrl,
    output logic [CNT_W-1:0]  timeout,
    output logic [CNT_W-1:0]  window,
    output logic [CNT_W-1:0]  count,
    output logic [STAT_W-1:0] status,
    output logic              expire,
    output logic              irq
);

    wdt_state_t        state_q, state_nxt;
    wdt_ctrl_t         ctrl_q, ctrl_nxt;
    logic [CNT_W-1:0]  timeout_q, timeout_nxt;
    logic [CNT_W-1:0]  window_q, window_nxt;
    logic [CNT_W-1:0]  count_q, count_nxt, count_dec;
    logic [STAT_W-1:0] status_q, status_nxt, status_set, status_clr;
    logic              key_ok;

    // State register: all channel state clears on synchronous reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            ctrl_q    <= '0;
            timeout_q <= '0;
            window_q  <= '0;
            count_q   <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_nxt;
            ctrl_q    <= ctrl_nxt;
            timeout_q <= timeout_nxt;
            window_q  <= window_nxt;
            count_q   <= count_nxt;
            status_q  <= status_nxt;
        end
    end

    // Next-state: config writes (lock-gated), FSM, counter and status set/clear
    always_comb begin
        ctrl_nxt    = ctrl_q;
        timeout_nxt = timeout_q;
        window_nxt  = window_q;
        state_nxt   = state_q;
        count_nxt   = count_q;
        status_set  = '0;
        status_clr  = '0;
        count_dec   = count_q - CNT_W'(1);
        key_ok      = (wdata == FEED_KEY);

        // Lock can only be set here (it is 0 whenever this write is honoured)
        if (wr_ctrl && !ctrl_q.lock)    ctrl_nxt    = wdt_ctrl_t'(wdata[CTRL_W-1:0]);
        if (wr_timeout && !ctrl_q.lock) timeout_nxt = wdata[CNT_W-1:0];
        if (wr_window && !ctrl_q.lock)  window_nxt  = wdata[CNT_W-1:0];
        if (wr_status)                  status_clr  = wdata[STAT_W-1:0];

        if (!ctrl_nxt.en) begin
            // Disabling parks the channel; counter and status are kept
            state_nxt = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    count_nxt = timeout_nxt;
                    state_nxt = ST_RUN;
                end
                ST_RUN, ST_WARN: begin
                    if (wr_feed) begin
                        if (!key_ok) begin
                            status_set[STAT_BAD_KEY] = 1'b1;
                            status_set[STAT_EXPIRED] = 1'b1;
                            state_nxt                = ST_EXPIRE;
                        end else if (ctrl_nxt.win_en && (count_q > window_nxt)) begin
                            status_set[STAT_EARLY]   = 1'b1;
                            status_set[STAT_EXPIRED] = 1'b1;
                            state_nxt                = ST_EXPIRE;
                        end else begin
                            // A valid feed beats a same-cycle zero count
                            count_nxt = timeout_nxt;
                            state_nxt = ST_RUN;
                        end
                    end else if (count_q == '0) begin
                        status_set[STAT_EXPIRED] = 1'b1;
                        state_nxt                = ST_EXPIRE;
                    end else begin
                        count_nxt = count_dec;
                        if (state_q == ST_RUN && count_dec == (timeout_nxt >> 2)) begin
                            status_set[STAT_WARN] = 1'b1;
                            state_nxt             = ST_WARN;
                        end
                    end
                end
                ST_EXPIRE: begin
                    count_nxt = timeout_nxt;
                    state_nxt = ST_RUN;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        // Hardware set wins over a same-cycle W1C clear
        status_nxt = (status_q & ~status_clr) | status_set;
    end

    assign ctrl    = ctrl_q;
    assign timeout = timeout_q;
    assign window  = window_q;
    assign count   = count_q;
    assign status  = status_q;
    assign expire  = (state_q == ST_EXPIRE);
    assign irq     = ctrl_q.irq_en & (|status_q);

endmodule

// File: rtl/watchdog_timer_mc.sv
// Multi-channel MMIO watchdog: address decode, read mux, irq vector, reset-request pulse.
// Latency: writes act at the strobe edge; rdata is combinational; wdt_reset lags EXPIRE by one cycle.
// Backpressure: none; the MMIO bus is never stalled.
module watchdog_timer_mc
    import wdt_pkg::*;
#(
    parameter int          NUM_CH    = 4,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
    parameter logic [31:0] FEED_KEY  = 32'h0000_A5A5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              w_en,
    input  logic              r_en,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic [NUM_CH-1:0] wdt_irq,
    output logic              wdt_reset
);

    localparam logic [31:0] MAP_SIZE = 32'(NUM_CH) * CH_STRIDE;

    logic [31:0] rel;
    logic        in_map;
    logic [4:0]  off;
    logic [2:0]  ch_idx;

    logic [CTRL_W-1:0] ctrl_a    [NUM_CH];
    logic [CNT_W-1:0]  timeout_a [NUM_CH];
    logic [CNT_W-1:0]  window_a  [NUM_CH];
    logic [CNT_W-1:0]  count_a   [NUM_CH];
    logic [STAT_W-1:0] status_a  [NUM_CH];
    logic [NUM_CH-1:0] expire_v;
    logic [NUM_CH-1:0] rst_en_v;

    // Offset from base; wrap-around makes addresses below base fall outside the map
    assign rel    = addr - BASE_ADDR;
    assign in_map = (rel < MAP_SIZE);
    assign off    = rel[4:0];
    assign ch_idx = rel[7:5];

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = w_en && in_map && (ch_idx == 3'(i));

        wdt_channel #(
            .CNT_W    (CNT_W),
            .FEED_KEY (FEED_KEY)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .wr_ctrl    (sel && (off == OFF_CTRL)),
            .wr_timeout (sel && (off == OFF_TIMEOUT)),
            .wr_window  (sel && (off == OFF_WINDOW)),
            .wr_feed    (sel && (off == OFF_FEED)),
            .wr_status  (sel && (off == OFF_STATUS)),
            .wdata      (wdata),
            .ctrl       (ctrl_a[i]),
            .timeout    (timeout_a[i]),
            .window     (window_a[i]),
            .count      (count_a[i]),
            .status     (status_a[i]),
            .expire     (expire_v[i]),
            .irq        (wdt_irq[i])
        );

        assign rst_en_v[i] = ctrl_a[i][CTRL_RST_EN];
    end

    // Read mux: zero-extended fields, zero for unmapped offsets or when not reading
    always_comb begin
        rdata = '0;
        if (r_en && in_map) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == 3'(i)) begin
                    case (off)
                        OFF_CTRL:    rdata = 32'(ctrl_a[i]);
                        OFF_TIMEOUT: rdata = 32'(timeout_a[i]);
                        OFF_WINDOW:  rdata = 32'(window_a[i]);
                        OFF_FEED:    rdata = 32'(count_a[i]);
                        OFF_STATUS:  rdata = 32'(status_a[i]);
                        default:     rdata = '0;
                    endcase
                end
            end
        end
    end

    // Reset request: one registered cycle per EXPIRE cycle of any rst_en channel
    always_ff @(posedge clk) begin
        if (!rst) wdt_reset <= 1'b0;
        else      wdt_reset <= |(expire_v & rst_en_v);
    end

endmodule

// File: tb/tb_watchdog_timer_mc.sv
// Directed bench for watchdog_timer_mc with a queue-based scoreboard.
// Latency: checks are issued one per cycle and compared on the following negedge.
// Backpressure: n/a.
module tb_watchdog_timer_mc;
    import wdt_pkg::*;

    localparam logic [31:0] BASE = 32'h4000_0000;
    localparam logic [31:0] KEY  = 32'h0000_A5A5;

    logic        clk;
    logic        rst;
    logic        w_en;
    logic        r_en;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [3:0]  wdt_irq;
    logic        wdt_reset;

    watchdog_timer_mc #(
        .NUM_CH    (4),
        .CNT_W     (32),
        .BASE_ADDR (BASE),
        .FEED_KEY  (KEY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .w_en      (w_en),
        .r_en      (r_en),
        .addr      (addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .wdt_irq   (wdt_irq),
        .wdt_reset (wdt_reset)
    );

    typedef struct {
        string       name;
        bit          is_rd;
        logic [31:0] exp;
        logic [31:0] mask;
        logic [3:0]  irq;
        logic        rst_req;
    } exp_t;

    exp_t sb[$];
    exp_t mon_it;
    logic probe;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;
    int   t0          = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops one expectation per probed cycle, compares away from the active edge
    always @(negedge clk) begin
        if (probe) begin
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL scoreboard_empty: probe with no expectation queued");
            end else begin
                mon_it = sb.pop_front();
                vectors++;
                if (mon_it.is_rd) begin
                    if ((rdata & mon_it.mask) !== mon_it.exp) begin
                        miscompares++;
                        $display("FAIL %s: rdata&mask got 0x%08h, want 0x%08h", mon_it.name,
                                 rdata & mon_it.mask, mon_it.exp);
                    end
                end else begin
                    if (wdt_irq !== mon_it.irq || wdt_reset !== mon_it.rst_req || rdata !== 32'h0) begin
                        miscompares++;
                        $display("FAIL %s: irq=%b rst=%b rdata=0x%08h, want irq=%b rst=%b rdata=0",
                                 mon_it.name, wdt_irq, wdt_reset, rdata, mon_it.irq, mon_it.rst_req);
                    end
                end
            end
        end
    end

    function automatic logic [31:0] ra(input int ch, input logic [4:0] off);
        return BASE + 32'(ch) * 32'h20 + 32'(off);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_edge(input int k);
        while (cyc < t0 + k) tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        w_en  = 1'b1;
        tick();
        w_en  = 1'b0;
    endtask

    task automatic chk_rd(input string nm, input logic [31:0] a, input logic [31:0] e,
                          input logic [31:0] m);
        exp_t it;
        it.name = nm; it.is_rd = 1'b1; it.exp = e & m; it.mask = m;
        it.irq = '0; it.rst_req = 1'b0;
        sb.push_back(it);
        addr  = a;
        r_en  = 1'b1;
        probe = 1'b1;
        tick();
        r_en  = 1'b0;
        probe = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic [3:0] irq_e, input logic rst_e);
        exp_t it;
        it.name = nm; it.is_rd = 1'b0; it.exp = '0; it.mask = '0;
        it.irq = irq_e; it.rst_req = rst_e;
        sb.push_back(it);
        r_en  = 1'b0;
        probe = 1'b1;
        tick();
        probe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b0; w_en = 1'b0; r_en = 1'b0; probe = 1'b0;
        addr = '0; wdata = '0;
        repeat (3) tick();
        rst = 1'b1;

        // Reset state
        chk_rd("rst_ctrl",    ra(0, OFF_CTRL),    32'h0, 32'hFFFF_FFFF);
        chk_rd("rst_timeout", ra(0, OFF_TIMEOUT), 32'h0, 32'hFFFF_FFFF);
        chk_rd("rst_count",   ra(0, OFF_FEED),    32'h0, 32'hFFFF_FFFF);
        chk_rd("rst_status",  ra(0, OFF_STATUS),  32'h0, 32'hFFFF_FFFF);
        chk_out("rst_outputs", 4'b0000, 1'b0);

        // Basic countdown: TIMEOUT=5, count 5..0, expire, reload
        wr(ra(0, OFF_TIMEOUT), 32'd5);
        wr(ra(0, OFF_CTRL), 32'h1);
        t0 = cyc;
        for (int k = 0; k < 6; k++)
            chk_rd($sformatf("cnt_edge%0d", k), ra(0, OFF_FEED), 32'(5 - k), 32'hFFFF_FFFF);
        chk_rd("basic_expired", ra(0, OFF_STATUS), 32'h2, 32'h2);
        chk_rd("basic_reload",  ra(0, OFF_FEED),   32'd5, 32'hFFFF_FFFF);
        wr(ra(0, OFF_CTRL), 32'h0);
        wr(ra(0, OFF_STATUS), 32'hF);
        chk_rd("basic_cleared", ra(0, OFF_STATUS), 32'h0, 32'hF);

        // Warn, irq and reset pulse: TIMEOUT=16, CTRL=en|irq_en|rst_en
        wr(ra(0, OFF_TIMEOUT), 32'd16);
        wr(ra(0, OFF_CTRL), 32'h7);
        t0 = cyc;
        at_edge(11); chk_rd("warn_before", ra(0, OFF_STATUS), 32'h0, 32'h1);
        at_edge(12); chk_rd("warn_at_4",   ra(0, OFF_STATUS), 32'h1, 32'h1);
        at_edge(13); chk_out("warn_irq",   4'b0001, 1'b0);
        at_edge(17); chk_out("expire_no_rst_yet", 4'b0001, 1'b0);
        at_edge(18); chk_out("rst_pulse",  4'b0001, 1'b1);
        at_edge(19); chk_out("rst_single", 4'b0001, 1'b0);
        at_edge(20); chk_rd("warn_expired", ra(0, OFF_STATUS), 32'h3, 32'h3);
        wr(ra(0, OFF_STATUS), 32'hF);
        chk_out("w1c_irq_drop", 4'b0000, 1'b0);
        wr(ra(0, OFF_CTRL), 32'h0);

        // Window: early feed at 50 expires, feed at 10 reloads
        wr(ra(0, OFF_TIMEOUT), 32'd100);
        wr(ra(0, OFF_WINDOW), 32'd20);
        wr(ra(0, OFF_CTRL), 32'h9);
        t0 = cyc;
        at_edge(50);
        wr(ra(0, OFF_FEED), KEY);
        chk_rd("early_feed", ra(0, OFF_STATUS), 32'h6, 32'hE);
        t0 = cyc;
        chk_rd("early_reload", ra(0, OFF_FEED), 32'd100, 32'hFFFF_FFFF);
        wr(ra(0, OFF_STATUS), 32'hF);
        at_edge(90);
        wr(ra(0, OFF_FEED), KEY);
        chk_rd("win_feed_reload", ra(0, OFF_FEED),   32'd100, 32'hFFFF_FFFF);
        chk_rd("win_feed_status", ra(0, OFF_STATUS), 32'h0,   32'hE);
        wr(ra(0, OFF_CTRL), 32'h0);
        wr(ra(0, OFF_STATUS), 32'hF);

        // Bad key, then valid feed on the zero-count cycle
        wr(ra(0, OFF_TIMEOUT), 32'd10);
        wr(ra(0, OFF_CTRL), 32'h1);
        t0 = cyc;
        at_edge(3);
        wr(ra(0, OFF_FEED), 32'h0000_1234);
        chk_rd("bad_key", ra(0, OFF_STATUS), 32'hA, 32'hE);
        t0 = cyc;
        wr(ra(0, OFF_STATUS), 32'hF);
        at_edge(10);
        wr(ra(0, OFF_FEED), KEY);
        chk_rd("feed_at_zero_reload", ra(0, OFF_FEED),   32'd10, 32'hFFFF_FFFF);
        chk_rd("feed_at_zero_noexp",  ra(0, OFF_STATUS), 32'h0,  32'h2);
        wr(ra(0, OFF_CTRL), 32'h0);
        wr(ra(0, OFF_STATUS), 32'hF);

        // Lock: config writes ignored while running, released only by reset
        wr(ra(0, OFF_TIMEOUT), 32'd20);
        wr(ra(0, OFF_CTRL), 32'h11);
        t0 = cyc;
        wr(ra(0, OFF_TIMEOUT), 32'd3);
        wr(ra(0, OFF_CTRL), 32'h0);
        chk_rd("lock_timeout", ra(0, OFF_TIMEOUT), 32'd20,  32'hFFFF_FFFF);
        chk_rd("lock_ctrl",    ra(0, OFF_CTRL),    32'h11,  32'hFFFF_FFFF);
        chk_rd("lock_running", ra(0, OFF_FEED),    32'd16,  32'hFFFF_FFFF);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_rd("mid_rst_ctrl",   ra(0, OFF_CTRL),   32'h0, 32'hFFFF_FFFF);
        chk_rd("mid_rst_count",  ra(0, OFF_FEED),   32'h0, 32'hFFFF_FFFF);
        chk_rd("mid_rst_status", ra(0, OFF_STATUS), 32'h0, 32'hFFFF_FFFF);
        wr(ra(0, OFF_TIMEOUT), 32'd7);
        chk_rd("unlock_timeout", ra(0, OFF_TIMEOUT), 32'd7, 32'hFFFF_FFFF);

        // TIMEOUT=0 on channel 1: expire every second cycle
        wr(ra(1, OFF_TIMEOUT), 32'd0);
        wr(ra(1, OFF_CTRL), 32'h5);
        t0 = cyc;
        at_edge(2); chk_out("t0_rst_a", 4'b0000, 1'b1);
        at_edge(3); chk_out("t0_rst_b", 4'b0000, 1'b0);
        at_edge(4); chk_out("t0_rst_c", 4'b0000, 1'b1);
        at_edge(5); chk_rd("t0_expired", ra(1, OFF_STATUS), 32'h2, 32'h2);
        wr(ra(1, OFF_CTRL), 32'h0);

        // Channels 0 and 2 with different timeouts; channel 3 isolation; unmapped reads
        wr(ra(0, OFF_TIMEOUT), 32'd8);
        wr(ra(2, OFF_TIMEOUT), 32'd40);
        wr(ra(3, OFF_TIMEOUT), 32'd5);
        wr(ra(0, OFF_CTRL), 32'h3);
        t0 = cyc;
        wr(ra(2, OFF_CTRL), 32'h3);
        at_edge(5);  chk_out("mc_none",   4'b0000, 1'b0);
        at_edge(6);  chk_out("mc_ch0",    4'b0001, 1'b0);
        at_edge(30); chk_out("mc_ch0_only", 4'b0001, 1'b0);
        at_edge(31); chk_out("mc_ch0_ch2",  4'b0101, 1'b0);
        chk_rd("mc_ch2_timeout", ra(2, OFF_TIMEOUT), 32'd40, 32'hFFFF_FFFF);
        chk_rd("mc_ch3_timeout", ra(3, OFF_TIMEOUT), 32'd5,  32'hFFFF_FFFF);
        chk_rd("mc_ch2_count",   ra(2, OFF_FEED),    32'd7,  32'hFFFF_FFFF);
        chk_rd("mc_ch3_status",  ra(3, OFF_STATUS),  32'h0,  32'hFFFF_FFFF);
        chk_rd("unmapped_ch4",   ra(4, OFF_CTRL),    32'h0,  32'hFFFF_FFFF);
        chk_rd("unmapped_off14", ra(0, 5'h14),       32'h0,  32'hFFFF_FFFF);
        chk_rd("below_base",     BASE - 32'd4,       32'h0,  32'hFFFF_FFFF);

        tick();
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
